bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 170 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// It handles one input bit per clock, so a conversion takes WIDTH clocks
// after the start edge. The result is held on bcd between conversions.
//
// Parameters
//   WIDTH   binary input width (1..16)
//   DIGITS  number of BCD digits; 10**DIGITS must exceed 2**WIDTH-1
//
// Ports
//   clk     sole clock, rising edge
//   reset   synchronous, active-high
//   start   conversion request, sampled in IDLE or DONE
//   bin     value to convert, sampled on the edge that accepts start
//   busy    high while shifting
//   done    one-cycle pulse when bcd has just been updated
//   bcd     packed BCD result, digit 0 (ones) in bits [3:0]
//   blank   (BIN2BCD_LEADING_BLANK_EN only) leading-zero blanking flags;
//           bit i is high when digit i and every higher digit are zero,
//           bit 0 is always low
//
// Build option
//   BIN2BCD_LEADING_BLANK_EN  adds the blank output and its logic
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | one add-3/shift step per clock, WIDTH steps in total
// DONE  | bcd just loaded, done high; start here chains a conversion
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_LEADING_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
    localparam bit              PARAMS_OK = (WIDTH >= 1) && (WIDTH <= 16) &&
                                            (pow10(DIGITS) > MAX_BIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [BW-1:0]    scratch;
    logic [WIDTH-1:0] sr;
    logic [4:0]       cnt;

    logic [BW-1:0]    adj;
    logic [SW-1:0]    shifted;
    logic             last;

    // Correct every digit that would overflow past 9 once doubled, then
    // shift the digits and the remaining input bits left as one word.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj, sr} << 1;
        last    = (cnt == 5'(WIDTH - 1));
    end

`ifdef BIN2BCD_LEADING_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] v);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (v[4*i +: 4] == 4'd0);
            b[i] = z;
        end
        return b;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            scratch <= '0;
            sr      <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BIN2BCD_LEADING_BLANK_EN
            blank   <= BLANK_RST;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sr      <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= shifted[SW-1:WIDTH];
                    sr      <= shifted[WIDTH-1:0];
                    cnt     <= cnt + 5'd1;
                    if (last) begin
                        bcd   <= shifted[SW-1:WIDTH];
`ifdef BIN2BCD_LEADING_BLANK_EN
                        blank <= blank_of(shifted[SW-1:WIDTH]);
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Simulation-only sanity checks: parameter legality and digit range.
    always_ff @(posedge clk) begin
        assert (PARAMS_OK)
            else $error("bin_to_bcd_seq: illegal WIDTH/DIGITS combination");
        if (!reset) begin
            for (int d = 0; d < DIGITS; d++) begin
                assert (scratch[4*d +: 4] <= 4'd9)
                    else $error("bin_to_bcd_seq: scratch digit above 9");
                assert (bcd[4*d +: 4] <= 4'd9)
                    else $error("bin_to_bcd_seq: output digit above 9");
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3).
// Expected results come from decimal arithmetic on the input value.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
`ifdef BIN2BCD_LEADING_BLANK_EN
    logic [2:0]  blank;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] prev_bcd;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_LEADING_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [2:0] blank_model(input int n);
        return {n < 100, n < 10, 1'b0};
    endfunction

    // Runs one conversion from the current cycle (IDLE or DONE state).
    // keep_start leaves start high so the DONE cycle chains the next one;
    // inject drives a spurious start/bin mid-conversion.
    task automatic convert(input int v, input bit keep_start, input bit inject);
        int k;
        int bc;
        bit seen;
        start = 1'b1;
        bin   = 8'(v);
        tick();
        if (!keep_start) start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("bcd_hold", {20'd0, bcd}, {20'd0, prev_bcd});
        bc   = busy ? 1 : 0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (inject && k == 3) begin
                start = 1'b1;
                bin   = 8'd7;
            end
            tick();
            k++;
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
        if (inject) start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("done_latency", k, 8);
        check("busy_cycles", bc, 8);
        check("bcd_value", {20'd0, bcd}, {20'd0, model(v)});
`ifdef BIN2BCD_LEADING_BLANK_EN
        check("blank_value", {29'd0, blank}, {29'd0, blank_model(v)});
`endif
        prev_bcd = model(v);
        if (!keep_start) begin
            tick();
            check("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int nd;
        reset    = 1'b1;
        start    = 1'b0;
        bin      = 8'd0;
        prev_bcd = 12'h000;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {20'd0, bcd}, 32'd0);
`ifdef BIN2BCD_LEADING_BLANK_EN
        check("rst_blank", {29'd0, blank}, 32'd6);
`endif
        reset = 1'b0;

        // start in the very first cycle after reset release
        convert(255, 1'b0, 1'b0);
        convert(0,   1'b0, 1'b0);
        convert(99,  1'b0, 1'b0);
        convert(100, 1'b0, 1'b0);
        convert(7,   1'b0, 1'b0);

        // start/bin changes while busy are ignored
        convert(200, 1'b0, 1'b1);

        // reset aborts a conversion with no done pulse
        start = 1'b1;
        bin   = 8'd123;
        tick();
        start = 1'b0;
        bin   = 8'd0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        prev_bcd = 12'h000;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcd", {20'd0, bcd}, 32'd0);
        nd = 0;
        repeat (12) begin
            tick();
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);

        // back-to-back conversions with start held high
        convert(42, 1'b1, 1'b0);
        convert(58, 1'b0, 1'b0);

        // randomized values with random idle gaps
        for (int i = 0; i < 24; i++) begin
            convert(int'($urandom_range(0, 255)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
